mem_stage_sram_ctrl: RTL and testbench
======================================

// Module: mem_stage_sram_ctrl
// PURPOSE
//  MEM-stage consumer of the EXE->MEM pipeline register outputs (MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm).
//  Performs 32-bit word loads and stores on an external 16-bit SRAM as two half-word accesses.
//  Deasserts ready to freeze the whole pipeline until the access completes.
//  Read data goes to the MEM->WB register.
// PARAMETERS
//  SRAM_AW      18    SRAM half-word address width
//  WAIT_CYCLES  2     cycles per half-word phase (>=1)
//  BASE_ADDR    1024  byte address that maps to SRAM address 0
// PORTS
//  clk          in   1   single clock; all logic on posedge
//  rst          in   1   synchronous reset, active-low
//  MEM_R_EN     in   1   load request (held by the frozen pipeline)
//  MEM_W_EN     in   1   store request (held by the frozen pipeline)
//  ALU_result   in   32  byte address of the access
//  Val_Rm       in   32  store data
//  ready        out  1   0 = freeze pipeline; 1 = MEM stage may advance
//  rdata        out  32  load result, registered
//  SRAM_ADDR    out  SRAM_AW  half-word address
//  SRAM_DQ_out  out  16  write data to pad
//  SRAM_DQ_oe   out  1   pad output enable (1 = drive DQ)
//  SRAM_DQ_in   in   16  read data from pad
//  SRAM_WE_N    out  1   write strobe, active-low
//  SRAM_OE_N    out  1   output enable, active-low
// BEHAVIOUR
//  - Address mapping
//    - word = (ALU_result - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
//    - LO phase: SRAM_ADDR = {word, 1'b0}, carries bits [15:0].
//    - HI phase: SRAM_ADDR = {word, 1'b1}, carries bits [31:16].
//  - Request and priority
//    - req = MEM_R_EN | MEM_W_EN.
//    - If both enables are high, the write wins and the read is ignored.
//  - State machine
//    - States: IDLE, LO, HI, DONE.
//    - IDLE -> LO when req = 1.
//    - LO -> HI after WAIT_CYCLES cycles.
//    - HI -> DONE after WAIT_CYCLES cycles.
//    - DONE -> IDLE unconditionally.
//  - ready = ~req | (state==DONE); this is combinational.
//    - Total stall for one access: 2*WAIT_CYCLES+1 cycles with ready low.
//    - ready is high in the DONE cycle.
//    - A back-to-back request restarts from IDLE in the following cycle.
//  - Write access
//    - SRAM_DQ_oe=1 and SRAM_WE_N=0 in every LO and HI cycle.
//    - SRAM_DQ_out = Val_Rm half for the current phase.
//  - Read access
//    - SRAM_OE_N=0 in LO and HI.
//    - SRAM_DQ_in is captured on the last cycle of each phase.
//    - rdata updates at the DONE edge with {hi, lo}.
//    - rdata holds its value until the next read completes; writes never change rdata.
//  - Idle drive: in IDLE and DONE, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0.
//  - A wait counter (width of WAIT_CYCLES) clears on every phase entry.
//  - Reset values (rst=0): state=IDLE, counter=0, rdata=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_out=0.
//    - ready then follows the ready rule above from the inputs.
//  - Reset mid-access: aborts the access on the next edge and leaves rdata=0.
//    - A partially written word is not rolled back.
//  - Inputs must be stable while ready=0. Input changes mid-access are not tracked; the latched phase data wins.
// CONFIGURATION
//  MEM_READ_HIT_BUFFER_EN defined:
//   - Adds a one-entry tag register (word + valid).
//   - Tag is set when a read completes.
//   - Tag is cleared by reset or by any write to the same word.
//   - A read in IDLE whose word matches a valid tag goes IDLE->DONE directly: 1 stall cycle, no SRAM strobes, rdata unchanged.
//  Undefined: every read takes the full LO/HI sequence; no tag storage exists.
// TESTING (WAIT_CYCLES=2, BASE_ADDR=1024)
//  1. Store
//     - Stimulus: MEM_W_EN=1, ALU_result=1024, Val_Rm=0xDEADBEEF.
//     - Response: SRAM addr 0 gets 0xBEEF, then addr 1 gets 0xDEAD.
//     - Response: ready low 5 cycles, high on cycle 5.
//  2. Load
//     - Stimulus: MEM_R_EN=1, ALU_result=1024 after test 1.
//     - Response: rdata=0xDEADBEEF in the DONE cycle, OE_N low 4 cycles.
//  3. Address mapping
//     - Stimulus: ALU_result=1032.
//     - Response: SRAM_ADDR=4 then 5.
//  4. Read/write priority
//     - Stimulus: MEM_R_EN=1 and MEM_W_EN=1, ALU_result=1028, Val_Rm=0x12345678.
//     - Response: a write to addrs 2/3 occurs and rdata is unchanged.
//  5. Reset mid-access
//     - Stimulus: rst=0 during the HI phase of a load.
//     - Response: next cycle state IDLE, all strobes inactive, rdata=0.
//  6. Hit buffer (MEM_READ_HIT_BUFFER_EN)
//     - Stimulus: repeat the load of 1024.
//     - Response: ready low 1 cycle, no strobes.
//     - Stimulus: a store to 1024, then load 1024.
//     - Response: the load takes the full 5 cycles.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_if.sv
// Bus bundle between the MEM pipeline stage, the SRAM controller and the external 16-bit SRAM pads.
interface mem_stage_sram_ctrl_if #(
    parameter int unsigned SRAM_AW = 18
);
    logic               MEM_R_EN;
    logic               MEM_W_EN;
    logic [31:0]        ALU_result;
    logic [31:0]        Val_Rm;
    logic               ready;
    logic [31:0]        rdata;
    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic [15:0]        SRAM_DQ_out;
    logic               SRAM_DQ_oe;
    logic [15:0]        SRAM_DQ_in;
    logic               SRAM_WE_N;
    logic               SRAM_OE_N;

    // Pipeline plus pad side: drives requests and read data, observes the controller.
    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm, SRAM_DQ_in,
        input  ready, rdata, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N
    );

    // Controller side.
    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm, SRAM_DQ_in,
        output ready, rdata, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: 32-bit word loads/stores as two half-word SRAM phases, freezing the pipeline meanwhile.
// Optional one-entry read hit buffer enabled by defining MEM_READ_HIT_BUFFER_EN.
module mem_stage_sram_ctrl #(
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_stage_sram_ctrl_if.slave  bus
);
    localparam int unsigned WORD_W = SRAM_AW - 1;
    localparam int unsigned CNT_W  = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [15:0]         lo_q, lo_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;
    logic                we_n_q, we_n_d;
    logic                oe_n_q, oe_n_d;

    logic                req_c;
    logic                wr_req_c;
    logic [31:0]         offs_c;
    logic [WORD_W-1:0]   word_c;
    logic                phase_end_c;
    logic                hit_c;

    logic                drive_c;
    logic                drive_hi_c;
    logic                drive_wr_c;
    logic [WORD_W-1:0]   drive_word_c;
    logic [31:0]         drive_wdata_c;

    assign req_c       = bus.MEM_R_EN | bus.MEM_W_EN;
    assign wr_req_c    = bus.MEM_W_EN;
    assign offs_c      = bus.ALU_result - 32'(BASE_ADDR);
    assign word_c      = WORD_W'(offs_c >> 2);
    assign phase_end_c = (cnt_q == CNT_LAST);

`ifdef MEM_READ_HIT_BUFFER_EN
    logic [WORD_W-1:0] tag_word_q, tag_word_d;
    logic              tag_valid_q, tag_valid_d;
    logic              rd_done_c;
    logic              wr_start_c;

    assign rd_done_c  = (state_q == S_HI) && phase_end_c && !wr_q;
    assign wr_start_c = (state_q == S_IDLE) && wr_req_c;
    assign hit_c      = bus.MEM_R_EN && !bus.MEM_W_EN && tag_valid_q && (tag_word_q == word_c);

    // Tag follows the last completed read; any store to that word invalidates it.
    always_comb begin
        tag_word_d  = tag_word_q;
        tag_valid_d = tag_valid_q;
        if (rd_done_c) begin
            tag_word_d  = word_q;
            tag_valid_d = 1'b1;
        end else if (wr_start_c && (tag_word_q == word_c)) begin
            tag_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_word_q  <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            tag_word_q  <= tag_word_d;
            tag_valid_q <= tag_valid_d;
        end
    end
`else
    assign hit_c = 1'b0;
`endif

    // Next state, phase latching and the pad drive for the upcoming cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_d          = wr_q;
        word_d        = word_q;
        wdata_d       = wdata_q;
        lo_d          = lo_q;
        rdata_d       = rdata_q;
        drive_c       = 1'b0;
        drive_hi_c    = 1'b0;
        drive_wr_c    = wr_q;
        drive_word_c  = word_q;
        drive_wdata_c = wdata_q;
        addr_d        = '0;
        dq_out_d      = '0;
        dq_oe_d       = 1'b0;
        we_n_d        = 1'b1;
        oe_n_d        = 1'b1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_c) begin
                    if (hit_c) begin
                        state_d = S_DONE;
                    end else begin
                        state_d       = S_LO;
                        wr_d          = wr_req_c;
                        word_d        = word_c;
                        wdata_d       = bus.Val_Rm;
                        drive_c       = 1'b1;
                        drive_wr_c    = wr_req_c;
                        drive_word_c  = word_c;
                        drive_wdata_c = bus.Val_Rm;
                    end
                end
            end
            S_LO: begin
                drive_c = 1'b1;
                if (phase_end_c) begin
                    state_d    = S_HI;
                    cnt_d      = '0;
                    drive_hi_c = 1'b1;
                    if (!wr_q) begin
                        lo_d = bus.SRAM_DQ_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HI: begin
                if (phase_end_c) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (!wr_q) begin
                        rdata_d = {bus.SRAM_DQ_in, lo_q};
                    end
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    drive_c    = 1'b1;
                    drive_hi_c = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (drive_c) begin
            addr_d = {drive_word_c, drive_hi_c};
            if (drive_wr_c) begin
                dq_oe_d  = 1'b1;
                we_n_d   = 1'b0;
                dq_out_d = drive_hi_c ? drive_wdata_c[31:16] : drive_wdata_c[15:0];
            end else begin
                oe_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            word_q   <= word_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
        end
    end

    // ready is the only combinational output: it must drop in the request cycle itself.
    assign bus.ready       = ~req_c | (state_q == S_DONE);
    assign bus.rdata       = rdata_q;
    assign bus.SRAM_ADDR   = addr_q;
    assign bus.SRAM_DQ_out = dq_out_q;
    assign bus.SRAM_DQ_oe  = dq_oe_q;
    assign bus.SRAM_WE_N   = we_n_q;
    assign bus.SRAM_OE_N   = oe_n_q;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: directed vector table, reset-abort sequence and
// randomized accesses against a word-level memory model with an SRAM pad model.
module tb_mem_stage_sram_ctrl;
    localparam int unsigned SRAM_AW     = 18;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam int unsigned BASE_ADDR   = 1024;
    localparam int          FULL        = 2 * WAIT_CYCLES + 1;
`ifdef MEM_READ_HIT_BUFFER_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif
    localparam int HIT_STALL = HIT_EN ? 1 : FULL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_sram_ctrl_if #(.SRAM_AW(SRAM_AW)) bus ();

    mem_stage_sram_ctrl #(
        .SRAM_AW    (SRAM_AW),
        .WAIT_CYCLES(WAIT_CYCLES),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // External SRAM: synchronous write on the strobe, asynchronous read while OE_N is low.
    logic [15:0] sram [0:(1<<SRAM_AW)-1];
    always @(posedge clk) begin
        if (!bus.SRAM_WE_N) sram[bus.SRAM_ADDR] <= bus.SRAM_DQ_out;
    end
    assign bus.SRAM_DQ_in = bus.SRAM_OE_N ? 16'h0000 : sram[bus.SRAM_ADDR];

    int n_cmp = 0;
    int n_bad = 0;

    // Word-level reference model.
    logic [31:0] ref_mem [int];
    logic        tag_v;
    int          tag_w;
    logic [31:0] last_rd;

    int          r_stall, r_we, r_oe, r_lo, r_hi, r_bad;
    logic        r_timeout;
    logic [31:0] r_rdata;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          stall;
        int          lo;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'(BASE_ADDR)) >> 2;
        return int'(off & ((32'd1 << (SRAM_AW - 1)) - 32'd1));
    endfunction

    function automatic logic idle_ok();
        return bus.SRAM_WE_N && bus.SRAM_OE_N && !bus.SRAM_DQ_oe && (bus.SRAM_ADDR == '0);
    endfunction

    // Applies one request and returns the expected stall and rdata; commits the model.
    task automatic model_step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                              output int stall, output logic [31:0] exp_rd);
        int wd;
        wd    = word_of(a);
        stall = FULL;
        if (w) begin
            ref_mem[wd] = d;
            if (tag_v && tag_w == wd) tag_v = 1'b0;
        end else if (r) begin
            if (HIT_EN && tag_v && tag_w == wd) begin
                stall = 1;
            end else begin
                last_rd = ref_mem.exists(wd) ? ref_mem[wd] : 32'h0;
                tag_v   = 1'b1;
                tag_w   = wd;
            end
        end
        exp_rd = last_rd;
    endtask

    task automatic set_inputs(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.MEM_R_EN   = r;
        bus.MEM_W_EN   = w;
        bus.ALU_result = a;
        bus.Val_Rm     = d;
    endtask

    // Presents one request and observes every cycle until ready returns.
    task automatic run_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                              input int lo_i);
        logic [SRAM_AW-1:0] lo;
        logic               done;
        lo = SRAM_AW'(lo_i);
        r_stall = 0; r_we = 0; r_oe = 0; r_lo = 0; r_hi = 0; r_bad = 0; r_rdata = '0;
        done = 1'b0;
        @(posedge clk); #1;
        set_inputs(r, w, a, d);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                done    = 1'b1;
                r_rdata = bus.rdata;
                if (!idle_ok()) r_bad++;
            end else begin
                r_stall++;
                if (!bus.SRAM_WE_N || !bus.SRAM_OE_N) begin
                    if (!bus.SRAM_WE_N) begin
                        r_we++;
                        if (!bus.SRAM_OE_N || !bus.SRAM_DQ_oe) r_bad++;
                    end else begin
                        r_oe++;
                        if (bus.SRAM_DQ_oe) r_bad++;
                    end
                    if (bus.SRAM_ADDR == lo) begin
                        r_lo++;
                        if (!bus.SRAM_WE_N && bus.SRAM_DQ_out != d[15:0]) r_bad++;
                    end else if (bus.SRAM_ADDR == lo + SRAM_AW'(1)) begin
                        r_hi++;
                        if (!bus.SRAM_WE_N && bus.SRAM_DQ_out != d[31:16]) r_bad++;
                    end else begin
                        r_bad++;
                    end
                end else if (!idle_ok()) begin
                    r_bad++;
                end
            end
        end
        r_timeout = !done;
    endtask

    task automatic check_access(input string nm, input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input int stall, input int lo, input logic [31:0] exp_rd);
        logic strobes;
        logic [SRAM_AW-1:0] la;
        run_access(r, w, a, d, lo);
        strobes = (stall != 1);
        la = SRAM_AW'(lo);
        chk({nm, " timeout"}, 64'(r_timeout), 64'(0));
        chk({nm, " stall"}, 64'(r_stall), 64'(stall));
        chk({nm, " we_cycles"}, 64'(r_we), 64'(w ? 2 * WAIT_CYCLES : 0));
        chk({nm, " oe_cycles"}, 64'(r_oe), 64'((!w && r && strobes) ? 2 * WAIT_CYCLES : 0));
        chk({nm, " lo_cycles"}, 64'(r_lo), 64'(strobes ? WAIT_CYCLES : 0));
        chk({nm, " hi_cycles"}, 64'(r_hi), 64'(strobes ? WAIT_CYCLES : 0));
        chk({nm, " pad_drive"}, 64'(r_bad), 64'(0));
        chk({nm, " rdata"}, 64'(r_rdata), 64'(exp_rd));
        if (w) chk({nm, " sram_word"}, 64'({sram[la + SRAM_AW'(1)], sram[la]}), 64'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic [31:0] erd;
        logic [31:0] a, d;
        logic        r, w;
        int          op;

        tag_v = 1'b0; tag_w = 0; last_rd = '0;
        rst = 1'b0;
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 64'(bus.ready), 64'(1));
        chk("reset rdata", 64'(bus.rdata), 64'(0));
        chk("reset idle_drive", 64'(idle_ok()), 64'(1));
        chk("reset dq_out", 64'(bus.SRAM_DQ_out), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        //          r     w     addr   data           stall      lo  rdata
        tbl[0] = '{1'b0, 1'b1, 1024, 32'hDEADBEEF, FULL,      0, 32'h00000000};
        tbl[1] = '{1'b1, 1'b0, 1024, 32'h00000000, FULL,      0, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b0, 1024, 32'h00000000, HIT_STALL, 0, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b1, 1024, 32'h0BADF00D, FULL,      0, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 1'b0, 1024, 32'h00000000, FULL,      0, 32'h0BADF00D};
        tbl[5] = '{1'b0, 1'b1, 1032, 32'hCAFEF00D, FULL,      4, 32'h0BADF00D};
        tbl[6] = '{1'b1, 1'b0, 1032, 32'h00000000, FULL,      4, 32'hCAFEF00D};
        tbl[7] = '{1'b1, 1'b1, 1028, 32'h12345678, FULL,      2, 32'hCAFEF00D};
        tbl[8] = '{1'b1, 1'b0, 1028, 32'h00000000, FULL,      2, 32'h12345678};
        tbl[9] = '{1'b1, 1'b0, 1035, 32'h00000000, FULL,      4, 32'hCAFEF00D};

        for (int i = 0; i < 10; i++) begin
            model_step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, st, erd);
            check_access($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d,
                         tbl[i].stall, tbl[i].lo, tbl[i].rd);
        end

        // Reset during the HI phase of a load aborts it and clears rdata.
        @(posedge clk); #1;
        set_inputs(1'b1, 1'b0, 1024, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort in_hi_phase", 64'({bus.SRAM_OE_N, bus.SRAM_ADDR}), 64'({1'b0, 18'd1}));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort idle_drive", 64'(idle_ok()), 64'(1));
        chk("abort rdata", 64'(bus.rdata), 64'(0));
        chk("abort ready_req_held", 64'(bus.ready), 64'(0));
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("abort ready_no_req", 64'(bus.ready), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        tag_v = 1'b0; last_rd = '0;

        model_step(1'b1, 1'b0, 1024, 32'h0, st, erd);
        check_access("post_abort_load", 1'b1, 1'b0, 1024, 32'h0, st, 0, erd);

        // Give every word of the random window a known value.
        for (int k = 0; k < 8; k++) begin
            a = 32'(BASE_ADDR) + 32'(4 * k);
            d = $urandom;
            model_step(1'b0, 1'b1, a, d, st, erd);
            check_access($sformatf("fill%0d", k), 1'b0, 1'b1, a, d, st, 2 * word_of(a), erd);
        end

        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 3));
            a  = 32'(BASE_ADDR) + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            d  = $urandom;
            if (op == 3) begin
                @(posedge clk); #1;
                set_inputs(1'b0, 1'b0, a, d);
                @(negedge clk);
                chk($sformatf("rnd%0d idle_ready", k), 64'(bus.ready), 64'(1));
                chk($sformatf("rnd%0d idle_rdata", k), 64'(bus.rdata), 64'(last_rd));
            end else begin
                r = (op == 0) || (op == 2);
                w = (op == 1) || (op == 2);
                model_step(r, w, a, d, st, erd);
                check_access($sformatf("rnd%0d", k), r, w, a, d, st, 2 * word_of(a), erd);
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk); #1;
                    set_inputs(1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
        end

        @(posedge clk); #1;
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
